// File: rtl/regfile_arbiter.sv
// regfile_arbiter: shares a single-write, dual-read register file between the
// core pipeline (port C, fixed priority) and the debug unit (port D). A
// starvation counter forces a debug grant after MAX_WAIT consecutive refusals.
// Read data from the register file is returned on the shared rsp_r1/rsp_r2
// buses, qualified by a per-port strobe one cycle after acceptance.
module regfile_arbiter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        c_valid,
    output logic        c_ready,
    input  logic        c_we,
    input  logic        c_re,
    input  logic [4:0]  c_rd,
    input  logic [4:0]  c_r1,
    input  logic [4:0]  c_r2,
    input  logic [31:0] c_wdata,

    input  logic        d_valid,
    output logic        d_ready,
    input  logic        d_we,
    input  logic        d_re,
    input  logic [4:0]  d_rd,
    input  logic [4:0]  d_r1,
    input  logic [4:0]  d_r2,
    input  logic [31:0] d_wdata,

    output logic        c_rsp_valid,
    output logic        d_rsp_valid,
    output logic [31:0] rsp_r1,
    output logic [31:0] rsp_r2,

    output logic [4:0]  rf_rd,
    output logic [4:0]  rf_r1,
    output logic [4:0]  rf_r2,
    output logic [31:0] rf_write_data,
    output logic        rf_w_en,
    output logic        rf_r_en,
    input  logic [31:0] rf_r1_read,
    input  logic [31:0] rf_r2_read
);

    localparam logic [3:0] MAX_WAIT_L = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RSP_C = 2'd1,
        RSP_D = 2'd2
    } rsp_state_t;

    rsp_state_t  r_state;
    logic [3:0]  r_d_wait;

    logic        w_force_d;
    logic        w_grant_c;
    logic        w_grant_d;

    // Debug wins when the core is idle or it has waited long enough; grants
    // are suppressed while reset is held so nothing reaches the register file.
    assign w_force_d = (r_d_wait == MAX_WAIT_L);
    assign w_grant_d = !rst && d_valid && (!c_valid || w_force_d);
    assign w_grant_c = !rst && c_valid && !w_grant_d;

    assign c_ready = w_grant_c;
    assign d_ready = w_grant_d;

    // Steer the winning request onto the register-file inputs; idle when nobody wins.
    always_comb begin
        rf_rd         = '0;
        rf_r1         = '0;
        rf_r2         = '0;
        rf_write_data = '0;
        rf_w_en       = 1'b0;
        rf_r_en       = 1'b0;
        if (w_grant_c) begin
            rf_rd         = c_rd;
            rf_r1         = c_r1;
            rf_r2         = c_r2;
            rf_write_data = c_wdata;
            rf_w_en       = c_we;
            rf_r_en       = c_re;
        end else if (w_grant_d) begin
            rf_rd         = d_rd;
            rf_r1         = d_r1;
            rf_r2         = d_r2;
            rf_write_data = d_wdata;
            rf_w_en       = d_we;
            rf_r_en       = d_re;
        end
    end

    // Count consecutive cycles debug is refused; saturates at the forcing threshold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d_wait <= 4'd0;
        end else if (d_valid && !w_grant_d) begin
            if (r_d_wait != MAX_WAIT_L) begin
                r_d_wait <= r_d_wait + 4'd1;
            end
        end else begin
            r_d_wait <= 4'd0;
        end
    end

    // Remember which port owns the read data returning next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else if (w_grant_c && c_re) begin
            r_state <= RSP_C;
        end else if (w_grant_d && d_re) begin
            r_state <= RSP_D;
        end else begin
            r_state <= IDLE;
        end
    end

    assign c_rsp_valid = (r_state == RSP_C);
    assign d_rsp_valid = (r_state == RSP_D);
    assign rsp_r1      = rf_r1_read;
    assign rsp_r2      = rf_r2_read;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Self-checking bench for regfile_arbiter: directed vector table, reset
// sequences, then constrained-random traffic against a transaction-level model.
module tb_regfile_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_valid, c_ready, c_we, c_re;
    logic [4:0]  c_rd, c_r1, c_r2;
    logic [31:0] c_wdata;
    logic        d_valid, d_ready, d_we, d_re;
    logic [4:0]  d_rd, d_r1, d_r2;
    logic [31:0] d_wdata;
    logic        c_rsp_valid, d_rsp_valid;
    logic [31:0] rsp_r1, rsp_r2;
    logic [4:0]  rf_rd, rf_r1, rf_r2;
    logic [31:0] rf_write_data;
    logic        rf_w_en, rf_r_en;
    logic [31:0] rf_r1_read, rf_r2_read;

    regfile_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .c_valid(c_valid), .c_ready(c_ready), .c_we(c_we), .c_re(c_re),
        .c_rd(c_rd), .c_r1(c_r1), .c_r2(c_r2), .c_wdata(c_wdata),
        .d_valid(d_valid), .d_ready(d_ready), .d_we(d_we), .d_re(d_re),
        .d_rd(d_rd), .d_r1(d_r1), .d_r2(d_r2), .d_wdata(d_wdata),
        .c_rsp_valid(c_rsp_valid), .d_rsp_valid(d_rsp_valid),
        .rsp_r1(rsp_r1), .rsp_r2(rsp_r2),
        .rf_rd(rf_rd), .rf_r1(rf_r1), .rf_r2(rf_r2),
        .rf_write_data(rf_write_data), .rf_w_en(rf_w_en), .rf_r_en(rf_r_en),
        .rf_r1_read(rf_r1_read), .rf_r2_read(rf_r2_read)
    );

    always #5 clk = ~clk;

    // Register file stand-in: registered reads (old value on same-edge write), x0 hardwired.
    logic [31:0] rf_mem [32] = '{default: 32'd0};
    always @(posedge clk) begin
        if (rf_r_en) begin
            rf_r1_read <= rf_mem[rf_r1];
            rf_r2_read <= rf_mem[rf_r2];
        end
        if (rf_w_en && rf_rd != 5'd0) rf_mem[rf_rd] <= rf_write_data;
    end

    typedef struct packed {
        logic        v, we, re;
        logic [4:0]  rd, r1, r2;
        logic [31:0] wd;
    } req_t;

    typedef struct packed {
        req_t        c, d;
        logic        egc, egd;   // expected grants this row
        logic        ecr, edr;   // expected response strobes this row
        logic        chk;        // compare rsp_r1 this row
        logic [31:0] er1;
    } vec_t;

    int n_vec  = 0;
    int n_fail = 0;

    // Transaction-level model state
    logic [31:0] shadow [32] = '{default: 32'd0};
    int          refused = 0;
    bit          exp_c_rsp = 0, exp_d_rsp = 0;
    logic [31:0] exp_r1 = 0, exp_r2 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic req_t rq(input logic v, we, re, input logic [4:0] rd, r1, r2,
                                input logic [31:0] wd);
        req_t r;
        r.v = v; r.we = we; r.re = re; r.rd = rd; r.r1 = r1; r.r2 = r2; r.wd = wd;
        return r;
    endfunction

    task automatic drive(input req_t c, input req_t d);
        c_valid = c.v; c_we = c.we; c_re = c.re; c_rd = c.rd; c_r1 = c.r1; c_r2 = c.r2;
        c_wdata = c.wd;
        d_valid = d.v; d_we = d.we; d_re = d.re; d_rd = d.rd; d_r1 = d.r1; d_r2 = d.r2;
        d_wdata = d.wd;
    endtask

    // One clock cycle: check responses owed from last cycle, apply the request
    // pair, check grant and register-file drive, then advance the model.
    task automatic step(input req_t c, input req_t d, output bit gc, output bit gd);
        req_t w;
        @(posedge clk); #1;
        check("c_rsp_valid", c_rsp_valid, exp_c_rsp);
        check("d_rsp_valid", d_rsp_valid, exp_d_rsp);
        if (exp_c_rsp || exp_d_rsp) begin
            check("rsp_r1", rsp_r1, exp_r1);
            check("rsp_r2", rsp_r2, exp_r2);
        end
        drive(c, d);
        #1;
        gd = d.v && (!c.v || refused >= MAX_WAIT);
        gc = c.v && !gd;
        check("c_ready", c_ready, gc);
        check("d_ready", d_ready, gd);
        w = gc ? c : (gd ? d : '0);
        check("rf_w_en", rf_w_en, w.we);
        check("rf_r_en", rf_r_en, w.re);
        check("rf_rd", rf_rd, w.rd);
        check("rf_r1", rf_r1, w.r1);
        check("rf_r2", rf_r2, w.r2);
        if (gc || gd) check("rf_write_data", rf_write_data, w.wd);
        exp_c_rsp = gc && c.re;
        exp_d_rsp = gd && d.re;
        if (w.re) begin
            exp_r1 = shadow[w.r1];
            exp_r2 = shadow[w.r2];
        end
        if (w.we && w.rd != 5'd0) shadow[w.rd] = w.wd;
        refused = (d.v && !gd) ? refused + 1 : 0;
    endtask

    function automatic req_t rand_req();
        return rq($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), $urandom);
    endfunction

    vec_t tbl[$];
    req_t idle, cst, dst, cr, dr;
    bit   gc, gd;

    initial begin
        idle = '0;
        drive(idle, idle);
        rst = 1'b1;

        // Reset state with both requesters asking
        drive(rq(1, 1, 1, 5'd1, 5'd1, 5'd1, 32'h1), rq(1, 1, 1, 5'd2, 5'd2, 5'd2, 32'h2));
        #12;
        check("rst_c_ready", c_ready, 0);
        check("rst_d_ready", d_ready, 0);
        check("rst_rf_w_en", rf_w_en, 0);
        check("rst_rf_r_en", rf_r_en, 0);
        check("rst_c_rsp_valid", c_rsp_valid, 0);
        check("rst_d_rsp_valid", d_rsp_valid, 0);
        drive(idle, idle);
        @(negedge clk); rst = 1'b0;

        cst = rq(1, 0, 1, 5'd0, 5'd5, 5'd0, 32'h0);
        dst = rq(1, 0, 1, 5'd0, 5'd7, 5'd0, 32'h0);
        //                c                                        d                                      gc gd cr dr chk r1
        tbl.push_back({rq(1,0,1,5'd0,5'd0,5'd0,32'h0),            idle,                                   1'b1,1'b0,1'b0,1'b0,1'b0,32'h0});
        tbl.push_back({idle,                                      idle,                                   1'b0,1'b0,1'b1,1'b0,1'b1,32'h0});
        tbl.push_back({rq(1,1,0,5'd5,5'd0,5'd0,32'hDEADBEEF),     idle,                                   1'b1,1'b0,1'b0,1'b0,1'b0,32'h0});
        tbl.push_back({idle,                                      rq(1,0,1,5'd0,5'd5,5'd0,32'h0),         1'b0,1'b1,1'b0,1'b0,1'b0,32'h0});
        tbl.push_back({rq(1,1,1,5'd7,5'd7,5'd0,32'h12345678),     idle,                                   1'b1,1'b0,1'b0,1'b1,1'b1,32'hDEADBEEF});
        tbl.push_back({rq(1,0,1,5'd0,5'd7,5'd5,32'h0),            idle,                                   1'b1,1'b0,1'b1,1'b0,1'b1,32'h0});
        tbl.push_back({idle,                                      rq(1,0,1,5'd0,5'd7,5'd5,32'h0),         1'b0,1'b1,1'b1,1'b0,1'b1,32'h12345678});
        tbl.push_back({rq(1,0,1,5'd0,5'd5,5'd7,32'h0),            idle,                                   1'b1,1'b0,1'b0,1'b1,1'b1,32'h12345678});
        tbl.push_back({idle,                                      idle,                                   1'b0,1'b0,1'b1,1'b0,1'b1,32'hDEADBEEF});
        for (int k = 0; k < 10; k++) begin
            tbl.push_back({cst, dst, 1'(k % 5 != 4), 1'(k % 5 == 4),
                           1'(k != 0 && k != 5), 1'(k == 5), 1'(k != 0),
                           (k == 5) ? 32'h12345678 : 32'hDEADBEEF});
        end
        tbl.push_back({rq(1,0,0,5'd9,5'd9,5'd9,32'h55),           idle,                                   1'b1,1'b0,1'b0,1'b1,1'b1,32'h12345678});
        tbl.push_back({idle,                                      rq(1,1,0,5'd0,5'd0,5'd0,32'hFFFFFFFF),  1'b0,1'b1,1'b0,1'b0,1'b0,32'h0});
        tbl.push_back({rq(1,0,1,5'd0,5'd0,5'd7,32'h0),            idle,                                   1'b1,1'b0,1'b0,1'b0,1'b0,32'h0});
        tbl.push_back({idle,                                      idle,                                   1'b0,1'b0,1'b1,1'b0,1'b1,32'h0});

        foreach (tbl[i]) begin
            step(tbl[i].c, tbl[i].d, gc, gd);
            check($sformatf("tbl%0d_c_ready", i), c_ready, tbl[i].egc);
            check($sformatf("tbl%0d_d_ready", i), d_ready, tbl[i].egd);
            check($sformatf("tbl%0d_c_rsp", i), c_rsp_valid, tbl[i].ecr);
            check($sformatf("tbl%0d_d_rsp", i), d_rsp_valid, tbl[i].edr);
            if (tbl[i].chk) check($sformatf("tbl%0d_rsp_r1", i), rsp_r1, tbl[i].er1);
        end

        // Reset right after an accepted read: strobe discarded, earlier write kept
        step(rq(1, 1, 0, 5'd3, 5'd0, 5'd0, 32'h1), idle, gc, gd);
        step(rq(1, 0, 1, 5'd0, 5'd3, 5'd0, 32'h0), idle, gc, gd);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(rq(1, 1, 1, 5'd3, 5'd3, 5'd3, 32'h9), rq(1, 1, 1, 5'd4, 5'd4, 5'd4, 32'h8));
        #1;
        check("midrst_c_rsp_valid", c_rsp_valid, 0);
        check("midrst_d_rsp_valid", d_rsp_valid, 0);
        check("midrst_c_ready", c_ready, 0);
        check("midrst_d_ready", d_ready, 0);
        check("midrst_rf_w_en", rf_w_en, 0);
        check("midrst_rf_r_en", rf_r_en, 0);
        exp_c_rsp = 0; exp_d_rsp = 0; refused = 0;
        drive(idle, idle);
        @(posedge clk); #3;
        rst = 1'b0;
        step(idle, idle, gc, gd);
        step(idle, idle, gc, gd);
        step(rq(1, 0, 1, 5'd0, 5'd3, 5'd0, 32'h0), idle, gc, gd);
        step(idle, idle, gc, gd);
        check("x3_retained_valid", c_rsp_valid, 1);
        check("x3_retained_data", rsp_r1, 32'h1);

        // Randomized traffic honouring hold-until-ready
        cr = '0; dr = '0; gc = 1; gd = 1;
        for (int n = 0; n < 3000; n++) begin
            if (!cr.v || gc) cr = rand_req();
            if (!dr.v || gd) begin
                dr = rand_req();
                dr.v = ($urandom_range(0, 1) == 1);
            end
            step(cr, dr, gc, gd);
        end
        step(idle, idle, gc, gd);
        step(idle, idle, gc, gd);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Shares the single-write, dual-read `register_file` between two requesters: the core pipeline (port C) and the debug unit (port D). Core has fixed priority, and a starvation counter guarantees debug forward progress. The block drives the register file's `rd/r1/r2/write_data/w_en/r_en` inputs and routes its registered read data back to the requester that was granted.

## Interface
Parameters:
- `MAX_WAIT`, 4: consecutive cycles debug may be refused while valid before it is forced to win (1..15).

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `c_valid`, `d_valid`  in  1  request valid, core/debug.
- `c_ready`, `d_ready`  out  1  grant; request accepted on a cycle where valid && ready.
- `c_we`, `d_we`  in  1  request includes a write.
- `c_re`, `d_re`  in  1  request includes a read of r1/r2.
- `c_rd`, `d_rd`, `c_r1`, `d_r1`, `c_r2`, `d_r2`  in  5  register indices.
- `c_wdata`, `d_wdata`  in  32  write data.
- `c_rsp_valid`, `d_rsp_valid`  out  1  read response valid, one cycle per accepted read.
- `rsp_r1`, `rsp_r2`  out  32  read data, shared by both ports; qualified by the `*_rsp_valid` strobes.
- `rf_rd`, `rf_r1`, `rf_r2`  out  5  to the register file.
- `rf_write_data`  out  32  to the register file.
- `rf_w_en`, `rf_r_en`  out  1  to the register file.
- `rf_r1_read`, `rf_r2_read`  in  32  from the register file (registered read data).

## Operation
- Grant is combinational in the same cycle; only one requester is granted per cycle.
- Arbitration:
  - Default: core wins.
  - Debug wins if `c_valid` == 0, or if `d_wait` == `MAX_WAIT`.
- `d_wait` counter (4 bit, reset 0):
  - Increments each cycle `d_valid` && !`d_ready`, saturating at `MAX_WAIT`.
  - Clears on a debug grant or when `d_valid` == 0.
- Granted request drives the register file directly:
  - `rf_rd/r1/r2/write_data` come from the winner's fields.
  - `rf_w_en` = winner `we`; `rf_r_en` = winner `re`.
- No grant: `rf_w_en` = `rf_r_en` = 0 and indices = 0.
- Write with `rd` = 0 is forwarded unchanged; the register file discards it.
- Response tracking uses a 2-bit state: IDLE, RSP_C, RSP_D.
  - Next state is RSP_C or RSP_D when a read is accepted from that port, else IDLE.
  - Transitions occur every cycle, so back-to-back reads are supported.
- `c_rsp_valid` = (state == RSP_C); `d_rsp_valid` = (state == RSP_D).
- `rsp_r1/rsp_r2` pass through `rf_r1_read/rf_r2_read`.
- A requester must hold valid and all fields stable until ready is high.
- Requests are never dropped and never reordered within a port.

## Timing
- Read latency: request accepted at edge N gives response valid in cycle N+1, for exactly one cycle. No backpressure on responses.
- Write takes effect at the accepting edge. A read of the same register in the same request returns the OLD value. A read accepted in the following cycle returns the new value.
- A core write at N followed by a debug read of the same register at N+1 returns the new value.
- Throughput: one access per cycle.
- Reset values:
  - `c_rsp_valid` = `d_rsp_valid` = 0; state = IDLE; `d_wait` = 0.
  - All `rf_*` enables 0 and `*_ready` = 0 while `rst` is high.
- Reset mid-operation: any in-flight response is discarded (no `*_rsp_valid` after reset deasserts). Writes already clocked into the register file are retained.
- Simultaneous `c_valid` && `d_valid` with `d_wait` < `MAX_WAIT`: core granted, `d_wait`++.
- With `MAX_WAIT` = 4 and continuous core traffic, debug is granted on its 5th valid cycle. The core is stalled that cycle and `d_wait` returns to 0.
- Request with `we` = `re` = 0 is accepted in one cycle with no register-file effect and no response.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → all `*_ready`, `*_rsp_valid`, and `rf_*_en` outputs are 0 immediately. After release, first `c_valid` read of x0 → `c_rsp_valid` next cycle with `rsp_r1` = 0.
- Core writes x5 = 32'hDEADBEEF at cycle N, debug reads r1 = 5 at N+1 → `d_rsp_valid` at N+2 with `rsp_r1` = 32'hDEADBEEF; `c_rsp_valid` stays 0.
- Same-request RAW: core writes x7 = 32'h12345678 and reads r1 = 7 in one request (x7 was 0) → response `rsp_r1` = 0. A repeat read → 32'h12345678.
- Starvation: `c_valid` held high continuously with `d_valid` high (`MAX_WAIT` = 4) → `d_ready` high on cycle 5, `c_ready` low that cycle. Debug accepted exactly once per 5 cycles.
- Back-to-back alternating reads C, D, C → `c_rsp_valid`, `d_rsp_valid`, `c_rsp_valid` on consecutive cycles, each with the correct data.
- Reset asserted in the cycle after an accepted read → no response strobe; a prior write to x3 = 1 is still readable after reset.
